// File: rtl/mem_access_pkg.sv
// Shared widths, FSM state codes, access-size codes and request record
// for the load/store unit.
package mem_access_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int BYTE_SEL       = 4;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [BYTE_SEL-1:0] SEL_BYTE = 4'b0001;
    localparam logic [BYTE_SEL-1:0] SEL_HALF = 4'b0011;
    localparam logic [BYTE_SEL-1:0] SEL_WORD = 4'b1111;

    typedef struct packed {
        logic                      we;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [BYTE_SEL-1:0]       byte_sel;
        logic                      un_sign;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      legal;
    } req_t;

    function automatic logic sel_legal(input logic [BYTE_SEL-1:0] sel);
        return (sel == SEL_BYTE) || (sel == SEL_HALF) || (sel == SEL_WORD);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request, RAM and write-back signals of the load/store unit.
// slave: the unit itself; master: the surrounding pipeline and RAM.
interface mem_access_if;
    import mem_access_pkg::*;

    logic                      mem_re_i;
    logic [MEM_ADDR_WIDTH-1:0] mem_raddr_i;
    logic                      mem_we_i;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr_i;
    logic [DATA_WIDTH-1:0]     mem_wdata_i;
    logic [BYTE_SEL-1:0]       byte_sel_i;
    logic                      un_sign_i;
    logic [REG_ADDR_WIDTH-1:0] rd_waddr_i;
    logic                      hold_o;

    logic                      ram_req_o;
    logic                      ram_we_o;
    logic [MEM_ADDR_WIDTH-1:0] ram_addr_o;
    logic [BYTE_SEL-1:0]       ram_be_o;
    logic [DATA_WIDTH-1:0]     ram_wdata_o;
    logic                      ram_ack_i;
    logic [DATA_WIDTH-1:0]     ram_rdata_i;

    logic                      rd_we_o;
    logic [REG_ADDR_WIDTH-1:0] rd_waddr_o;
    logic [DATA_WIDTH-1:0]     rd_wdata_o;

    modport slave (
        input  mem_re_i, mem_raddr_i, mem_we_i, mem_waddr_i, mem_wdata_i,
        input  byte_sel_i, un_sign_i, rd_waddr_i, ram_ack_i, ram_rdata_i,
        output hold_o, ram_req_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o,
        output rd_we_o, rd_waddr_o, rd_wdata_o
    );

    modport master (
        output mem_re_i, mem_raddr_i, mem_we_i, mem_waddr_i, mem_wdata_i,
        output byte_sel_i, un_sign_i, rd_waddr_i, ram_ack_i, ram_rdata_i,
        input  hold_o, ram_req_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o,
        input  rd_we_o, rd_waddr_o, rd_wdata_o
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/byte-enable placement across one or two
// RAM words, and load byte gathering with sign/zero extension.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]            offset,
    input  logic [BYTE_SEL-1:0]   byte_sel,
    input  logic                  un_sign,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] word_lo,
    input  logic [DATA_WIDTH-1:0] word_hi,
    output logic [BYTE_SEL-1:0]   be_lo,
    output logic [BYTE_SEL-1:0]   be_hi,
    output logic [DATA_WIDTH-1:0] wdata_lo,
    output logic [DATA_WIDTH-1:0] wdata_hi,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  split
);

    logic [2*BYTE_SEL-1:0]   be_wide;
    logic [2*DATA_WIDTH-1:0] wdata_wide;
    logic [DATA_WIDTH-1:0]   data_mask;
    logic [DATA_WIDTH-1:0]   raw;

    // Shift size mask and masked store data up by the byte offset; the
    // part that spills past bit 31 belongs to the following word.
    always_comb begin
        data_mask  = {{8{byte_sel[3]}}, {8{byte_sel[2]}},
                      {8{byte_sel[1]}}, {8{byte_sel[0]}}};
        be_wide    = {4'b0000, byte_sel} << offset;
        wdata_wide = {32'h0, store_data & data_mask} << {offset, 3'b000};
        be_lo      = be_wide[3:0];
        be_hi      = be_wide[7:4];
        wdata_lo   = wdata_wide[31:0];
        wdata_hi   = wdata_wide[63:32];
        split      = |be_wide[7:4];
    end

    // Right-align the addressed bytes from the one or two fetched words,
    // then extend to the register width.
    always_comb begin
        raw = 32'({word_hi, word_lo} >> {offset, 3'b000});
        case (byte_sel)
            SEL_BYTE: load_data = un_sign ? {{24{raw[7]}}, raw[7:0]}
                                          : {24'h0, raw[7:0]};
            SEL_HALF: load_data = un_sign ? {{16{raw[15]}}, raw[15:0]}
                                          : {16'h0, raw[15:0]};
            default:  load_data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store unit: accepts one request at a time, performs one or two
// RAM word accesses, and returns the load result for one cycle.
//
//   state | meaning
//   IDLE  | waiting for a load or store request
//   ACC0  | RAM access to the word holding the first byte
//   ACC1  | RAM access to the next word for accesses crossing a boundary
//   RESP  | one-cycle result; register write-back for loads
module mem_access
    import mem_access_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    req_t                      req_q;
    logic [DATA_WIDTH-1:0]     word0_q;
    logic [DATA_WIDTH-1:0]     word1_q;
    logic                      start;

    logic [BYTE_SEL-1:0]       be_lo;
    logic [BYTE_SEL-1:0]       be_hi;
    logic [DATA_WIDTH-1:0]     wdata_lo;
    logic [DATA_WIDTH-1:0]     wdata_hi;
    logic [DATA_WIDTH-1:0]     load_data;
    logic                      split;

    logic                      ram_req;
    logic                      ram_we;
    logic [MEM_ADDR_WIDTH-1:0] ram_addr;
    logic [BYTE_SEL-1:0]       ram_be;
    logic [DATA_WIDTH-1:0]     ram_wdata;
    logic                      rd_we;
    logic [REG_ADDR_WIDTH-1:0] rd_waddr;
    logic [DATA_WIDTH-1:0]     rd_wdata;

    assign start = bus.mem_re_i | bus.mem_we_i;

    mem_lane_align u_lane (
        .offset     (req_q.addr[1:0]),
        .byte_sel   (req_q.byte_sel),
        .un_sign    (req_q.un_sign),
        .store_data (req_q.wdata),
        .word_lo    (word0_q),
        .word_hi    (word1_q),
        .be_lo      (be_lo),
        .be_hi      (be_hi),
        .wdata_lo   (wdata_lo),
        .wdata_hi   (wdata_hi),
        .load_data  (load_data),
        .split      (split)
    );

    // Next-state: illegal sizes skip the RAM and go straight to RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = sel_legal(bus.byte_sel_i) ? ST_ACC0 : ST_RESP;
            ST_ACC0: if (bus.ram_ack_i) state_nxt = split ? ST_ACC1 : ST_RESP;
            ST_ACC1: if (bus.ram_ack_i) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Request capture; a simultaneous store wins over the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (state == ST_IDLE && start) begin
            req_q.we       <= bus.mem_we_i;
            req_q.addr     <= bus.mem_we_i ? bus.mem_waddr_i : bus.mem_raddr_i;
            req_q.wdata    <= bus.mem_wdata_i;
            req_q.byte_sel <= bus.byte_sel_i;
            req_q.un_sign  <= bus.un_sign_i;
            req_q.rd       <= bus.rd_waddr_i;
            req_q.legal    <= sel_legal(bus.byte_sel_i);
        end
    end

    // Read words latched on the acknowledge of each access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            if (state == ST_ACC0 && bus.ram_ack_i) word0_q <= bus.ram_rdata_i;
            if (state == ST_ACC1 && bus.ram_ack_i) word1_q <= bus.ram_rdata_i;
        end
    end

    // Output decode: everything idles at zero outside its own state.
    always_comb begin
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_be    = '0;
        ram_wdata = '0;
        rd_we     = 1'b0;
        rd_waddr  = '0;
        rd_wdata  = '0;
        case (state)
            ST_ACC0: begin
                ram_req   = 1'b1;
                ram_we    = req_q.we;
                ram_addr  = {req_q.addr[31:2], 2'b00};
                ram_be    = be_lo;
                ram_wdata = wdata_lo;
            end
            ST_ACC1: begin
                ram_req   = 1'b1;
                ram_we    = req_q.we;
                ram_addr  = {req_q.addr[31:2] + 30'd1, 2'b00};
                ram_be    = be_hi;
                ram_wdata = wdata_hi;
            end
            ST_RESP: begin
                rd_we    = !req_q.we && req_q.legal && (req_q.rd != '0);
                rd_waddr = req_q.rd;
                rd_wdata = rd_we ? load_data : '0;
            end
            default: ;
        endcase
    end

    assign bus.hold_o      = rst_n && (state != ST_RESP) && ((state != ST_IDLE) || start);
    assign bus.ram_req_o   = ram_req;
    assign bus.ram_we_o    = ram_we;
    assign bus.ram_addr_o  = ram_addr;
    assign bus.ram_be_o    = ram_be;
    assign bus.ram_wdata_o = ram_wdata;
    assign bus.rd_we_o     = rd_we;
    assign bus.rd_waddr_o  = rd_waddr;
    assign bus.rd_wdata_o  = rd_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: the bench plays both pipeline and RAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access;
    import mem_access_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_access_if bus ();

    mem_access u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.mem_re_i    = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_raddr_i = '0;
        bus.mem_waddr_i = '0;
        bus.mem_wdata_i = '0;
        bus.byte_sel_i  = '0;
        bus.un_sign_i   = 1'b0;
        bus.rd_waddr_i  = '0;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, input logic sgn, input logic [4:0] rd);
        bus.mem_re_i    = !we;
        bus.mem_we_i    = we;
        bus.mem_raddr_i = addr;
        bus.mem_waddr_i = addr;
        bus.mem_wdata_i = wdata;
        bus.byte_sel_i  = sel;
        bus.un_sign_i   = sgn;
        bus.rd_waddr_i  = rd;
    endtask

    // One-word access: issue, check ACC0, acknowledge, check RESP.
    task automatic single(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel, input logic sgn,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic e_rd_we,
                          input logic [31:0] e_res);
        req(we, addr, wdata, sel, sgn, rd);
        step();
        idle_in();
        chk({tag, "_req"},  32'(bus.ram_req_o), 32'd1);
        chk({tag, "_we"},   32'(bus.ram_we_o), 32'(we));
        chk({tag, "_addr"}, bus.ram_addr_o, e_addr);
        chk({tag, "_be"},   32'(bus.ram_be_o), 32'(e_be));
        if (we) chk({tag, "_wdata"}, bus.ram_wdata_o, e_wdata);
        bus.ram_ack_i   = 1'b1;
        bus.ram_rdata_i = rdata;
        step();
        bus.ram_ack_i   = 1'b0;
        bus.ram_rdata_i = '0;
        chk({tag, "_rdwe"}, 32'(bus.rd_we_o), 32'(e_rd_we));
        if (e_rd_we) begin
            chk({tag, "_rdaddr"}, 32'(bus.rd_waddr_o), 32'(rd));
            chk({tag, "_result"}, bus.rd_wdata_o, e_res);
        end
        chk({tag, "_resp_hold"}, 32'(bus.hold_o), 32'd0);
        step();
    endtask

    // Boundary-crossing access: two RAM words, then RESP.
    task automatic split2(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel, input logic sgn,
                          input logic [4:0] rd, input logic [31:0] rd0, input logic [31:0] rd1,
                          input logic [31:0] e_a0, input logic [3:0] e_be0, input logic [31:0] e_wd0,
                          input logic [31:0] e_a1, input logic [3:0] e_be1, input logic [31:0] e_wd1,
                          input logic [31:0] e_res);
        req(we, addr, wdata, sel, sgn, rd);
        step();
        idle_in();
        chk({tag, "_a0"},  bus.ram_addr_o, e_a0);
        chk({tag, "_be0"}, 32'(bus.ram_be_o), 32'(e_be0));
        if (we) chk({tag, "_wd0"}, bus.ram_wdata_o, e_wd0);
        bus.ram_ack_i   = 1'b1;
        bus.ram_rdata_i = rd0;
        step();
        bus.ram_rdata_i = rd1;
        chk({tag, "_req1"}, 32'(bus.ram_req_o), 32'd1);
        chk({tag, "_hold1"}, 32'(bus.hold_o), 32'd1);
        chk({tag, "_a1"},  bus.ram_addr_o, e_a1);
        chk({tag, "_be1"}, 32'(bus.ram_be_o), 32'(e_be1));
        if (we) chk({tag, "_wd1"}, bus.ram_wdata_o, e_wd1);
        step();
        bus.ram_ack_i   = 1'b0;
        bus.ram_rdata_i = '0;
        chk({tag, "_rdwe"}, 32'(bus.rd_we_o), 32'(!we));
        if (!we) chk({tag, "_result"}, bus.rd_wdata_o, e_res);
        step();
    endtask

    initial begin
        idle_in();
        bus.ram_ack_i   = 1'b0;
        bus.ram_rdata_i = '0;
        step();
        step();

        // Reset holds everything at zero even with a request pending.
        req(1'b0, 32'h100, 32'h0, 4'b1111, 1'b0, 5'd5);
        #1;
        chk("rst_hold",  32'(bus.hold_o), 32'd0);
        chk("rst_req",   32'(bus.ram_req_o), 32'd0);
        chk("rst_we",    32'(bus.ram_we_o), 32'd0);
        chk("rst_rdwe",  32'(bus.rd_we_o), 32'd0);
        chk("rst_addr",  bus.ram_addr_o, 32'h0);
        chk("rst_be",    32'(bus.ram_be_o), 32'h0);
        chk("rst_wdata", bus.ram_wdata_o, 32'h0);
        chk("rst_rdata", bus.rd_wdata_o, 32'h0);

        // lw 0x100 accepted on the first edge after reset release.
        step();
        rst_n = 1'b1;
        #1;
        chk("lw_hold_req", 32'(bus.hold_o), 32'd1);
        step();
        idle_in();
        chk("lw_req",  32'(bus.ram_req_o), 32'd1);
        chk("lw_addr", bus.ram_addr_o, 32'h100);
        chk("lw_be",   32'(bus.ram_be_o), 32'hF);
        chk("lw_we",   32'(bus.ram_we_o), 32'd0);
        chk("lw_hold", 32'(bus.hold_o), 32'd1);
        bus.ram_ack_i   = 1'b1;
        bus.ram_rdata_i = 32'hDEADBEEF;
        step();
        bus.ram_ack_i   = 1'b0;
        bus.ram_rdata_i = '0;
        chk("lw_rdwe",   32'(bus.rd_we_o), 32'd1);
        chk("lw_rdaddr", 32'(bus.rd_waddr_o), 32'd5);
        chk("lw_result", bus.rd_wdata_o, 32'hDEADBEEF);
        chk("lw_resp_hold", 32'(bus.hold_o), 32'd0);
        chk("lw_resp_req",  32'(bus.ram_req_o), 32'd0);
        step();
        chk("lw_idle_rdwe", 32'(bus.rd_we_o), 32'd0);

        single("lh_sext", 1'b0, 32'h102, 32'h0, 4'b0011, 1'b1, 5'd7, 32'h80010000,
               32'h100, 4'b1100, 32'h0, 1'b1, 32'hFFFF8001);
        single("lh_zext", 1'b0, 32'h102, 32'h0, 4'b0011, 1'b0, 5'd7, 32'h80010000,
               32'h100, 4'b1100, 32'h0, 1'b1, 32'h00008001);
        single("lb_sext", 1'b0, 32'h101, 32'h0, 4'b0001, 1'b1, 5'd3, 32'h00008000,
               32'h100, 4'b0010, 32'h0, 1'b1, 32'hFFFFFF80);
        single("sb", 1'b1, 32'h107, 32'h000000A5, 4'b0001, 1'b0, 5'd0, 32'h0,
               32'h104, 4'b1000, 32'hA5000000, 1'b0, 32'h0);
        single("sh", 1'b1, 32'h202, 32'hFFFF1234, 4'b0011, 1'b0, 5'd0, 32'h0,
               32'h200, 4'b1100, 32'h12340000, 1'b0, 32'h0);
        single("lw_r0", 1'b0, 32'h300, 32'h0, 4'b1111, 1'b0, 5'd0, 32'h12345678,
               32'h300, 4'b1111, 32'h0, 1'b0, 32'h0);

        split2("lw_split", 1'b0, 32'h0FE, 32'h0, 4'b1111, 1'b0, 5'd9,
               32'hBBBB0000, 32'h0000AAAA,
               32'h0FC, 4'b1100, 32'h0, 32'h100, 4'b0011, 32'h0, 32'hAAAABBBB);
        split2("lh_split", 1'b0, 32'h103, 32'h0, 4'b0011, 1'b0, 5'd10,
               32'h11000000, 32'h00000022,
               32'h100, 4'b1000, 32'h0, 32'h104, 4'b0001, 32'h0, 32'h00002211);
        split2("sw_wrap", 1'b1, 32'hFFFFFFFD, 32'hAABBCCDD, 4'b1111, 1'b0, 5'd0,
               32'h0, 32'h0,
               32'hFFFFFFFC, 4'b1110, 32'hBBCCDD00, 32'h0, 4'b0001, 32'h000000AA, 32'h0);

        // Acknowledge held off for three cycles: request stays stable.
        req(1'b1, 32'h200, 32'h12345678, 4'b1111, 1'b0, 5'd0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("wait_req",   32'(bus.ram_req_o), 32'd1);
            chk("wait_hold",  32'(bus.hold_o), 32'd1);
            chk("wait_addr",  bus.ram_addr_o, 32'h200);
            chk("wait_wdata", bus.ram_wdata_o, 32'h12345678);
            chk("wait_be",    32'(bus.ram_be_o), 32'hF);
            step();
        end
        bus.ram_ack_i = 1'b1;
        chk("wait_req_ack", 32'(bus.ram_req_o), 32'd1);
        step();
        bus.ram_ack_i = 1'b0;
        chk("wait_rdwe", 32'(bus.rd_we_o), 32'd0);
        chk("wait_resp_hold", 32'(bus.hold_o), 32'd0);
        step();

        // Store and load together: the store is performed.
        req(1'b1, 32'h500, 32'h00000055, 4'b1111, 1'b0, 5'd9);
        bus.mem_re_i    = 1'b1;
        bus.mem_raddr_i = 32'h400;
        step();
        idle_in();
        chk("both_we",    32'(bus.ram_we_o), 32'd1);
        chk("both_addr",  bus.ram_addr_o, 32'h500);
        chk("both_wdata", bus.ram_wdata_o, 32'h00000055);
        bus.ram_ack_i = 1'b1;
        step();
        bus.ram_ack_i = 1'b0;
        chk("both_rdwe", 32'(bus.rd_we_o), 32'd0);
        step();

        // Illegal size: IDLE -> RESP -> IDLE with no RAM access.
        req(1'b0, 32'h100, 32'h0, 4'b0111, 1'b0, 5'd3);
        step();
        idle_in();
        chk("ill_req",  32'(bus.ram_req_o), 32'd0);
        chk("ill_rdwe", 32'(bus.rd_we_o), 32'd0);
        chk("ill_hold", 32'(bus.hold_o), 32'd0);
        step();
        chk("ill_idle_req",  32'(bus.ram_req_o), 32'd0);
        chk("ill_idle_hold", 32'(bus.hold_o), 32'd0);

        // Stray acknowledge while idle has no effect.
        bus.ram_ack_i   = 1'b1;
        bus.ram_rdata_i = 32'h87654321;
        step();
        chk("stray_req",  32'(bus.ram_req_o), 32'd0);
        chk("stray_rdwe", 32'(bus.rd_we_o), 32'd0);
        step();
        chk("stray_rdwe2", 32'(bus.rd_we_o), 32'd0);
        bus.ram_ack_i   = 1'b0;
        bus.ram_rdata_i = '0;

        // Reset during ACC0 with the acknowledge arriving afterwards.
        req(1'b0, 32'h100, 32'h0, 4'b1111, 1'b0, 5'd4);
        step();
        idle_in();
        chk("mid_req_pre", 32'(bus.ram_req_o), 32'd1);
        rst_n           = 1'b0;
        bus.ram_ack_i   = 1'b1;
        bus.ram_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("mid_req",  32'(bus.ram_req_o), 32'd0);
        chk("mid_hold", 32'(bus.hold_o), 32'd0);
        chk("mid_addr", bus.ram_addr_o, 32'h0);
        chk("mid_be",   32'(bus.ram_be_o), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rdwe",  32'(bus.rd_we_o), 32'd0);
        chk("mid_req2",  32'(bus.ram_req_o), 32'd0);
        chk("mid_hold2", 32'(bus.hold_o), 32'd0);
        bus.ram_ack_i   = 1'b0;
        bus.ram_rdata_i = '0;
        step();
        chk("mid_rdwe2", 32'(bus.rd_we_o), 32'd0);

        single("lw_after", 1'b0, 32'h010, 32'h0, 4'b1111, 1'b0, 5'd12, 32'hCAFEF00D,
               32'h010, 4'b1111, 32'h0, 1'b1, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 mem_re_i / mem_raddr_i  in  1 / 32  load request and byte address from executrol.
REQ-004 mem_we_i / mem_waddr_i / mem_wdata_i  in  1 / 32 / 32  store request, byte address, store data (low bytes used).
REQ-005 byte_sel_i  in  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
REQ-006 un_sign_i  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
REQ-007 rd_waddr_i  in  5  load destination register.
REQ-008 hold_o  out  1  pipeline stall toward pc/executrol.
REQ-009 ram_req_o / ram_we_o  out  1 / 1  RAM request strobe, write qualifier.
REQ-010 ram_addr_o / ram_be_o / ram_wdata_o  out  32 / 4 / 32  word-aligned address ([1:0]=0), byte enables, lane-aligned write data.
REQ-011 ram_ack_i / ram_rdata_i  in  1 / 32  RAM completion and read word (valid with ack).
REQ-012 rd_we_o / rd_waddr_o / rd_wdata_o  out  1 / 5 / 32  register write-back of load result.

Function
REQ-013 FSM states IDLE, ACC0, ACC1, RESP; encoding in package.
REQ-014 IDLE: mem_we_i or mem_re_i high -> capture all request inputs, go ACC0; mem_we_i wins if both high (read dropped).
REQ-015 hold_o = (state != IDLE) | mem_re_i | mem_we_i, except low in RESP.
REQ-016 ACC0: ram_req_o high, held with address/be/data stable until ram_ack_i; no timeout.
REQ-017 Split: access crosses word boundary (half at offset 3; word at offset 1..3) -> ACC0 handles low word, ACC1 handles next word (addr+4); else ACC0 -> RESP.
REQ-018 ram_be_o = size mask shifted left by addr[1:0], truncated to 4 bits in ACC0; spill bits in ACC1; ram_wdata_o shifted same way.
REQ-019 Loads: bytes gathered from ack'd words, right-aligned, extended per byte_sel/un_sign.
REQ-020 RESP lasts exactly one cycle, then IDLE; loads: rd_we_o=1, rd_waddr_o=captured, rd_wdata_o=result; stores: rd_we_o=0.
REQ-021 Best-case latency: accept at T, ram_req_o at T+1, ack at T+1 -> RESP at T+2; split adds >=1 cycle.
REQ-022 Illegal byte_sel: no RAM access, IDLE -> RESP -> IDLE, rd_we_o=0.
REQ-023 rd_waddr_i = 0 load: RAM read performed, rd_we_o still 0.
REQ-024 ram_ack_i ignored outside ACC0/ACC1.
REQ-025 Address wrap 0xFFFFFFFC+4 -> 0x00000000 (mod 2^32).

Reset
REQ-026 rst low: state IDLE immediately; ram_req_o, ram_we_o, rd_we_o, hold_o = 0; all address/data/be outputs and capture registers = 0.
REQ-027 Reset mid-access abandons the transaction, no write-back; late ram_ack_i ignored.
REQ-028 First request accepted at first rising edge after rst deasserts.

Structure
REQ-029 defines.v holds FSM state codes, byte_sel size codes, width macros (DATA_WIDTH, MEM_ADDR_WIDTH, BYTE_SEL, REG_ADDR_WIDTH).
REQ-030 Sub-module mem_lane_align: combinational store shift/be generation and load extract/extension; FSM+capture in mem_access.

Verification
REQ-031 lw 0x100, ack next cycle, rdata 0xDEADBEEF -> RESP at T+2, rd_wdata_o=0xDEADBEEF, rd_we_o=1.
REQ-032 lh 0x102 sign, rdata 0x80010000 -> rd_wdata_o=0xFFFF8001; zero-ext -> 0x00008001.
REQ-033 sb 0x107 data 0x000000A5 -> ram_addr_o=0x104, ram_be_o=4'b1000, ram_wdata_o=0xA5000000, rd_we_o=0.
REQ-034 lw 0x0FE split, words 0xBBBB0000/0x0000AAAA -> two requests 0x0FC/0x100, rd_wdata_o=0xAAAABBBB.
REQ-035 ack delayed 3 cycles -> ram_req_o and hold_o high throughout, outputs stable.
REQ-036 rst low during ACC0, ack next cycle -> no rd_we_o, state IDLE, all outputs 0.
